// File: rtl/des_f_serial.sv
// des_f_serial: serialized DES Feistel f-function; one S-box lookup per cycle,
// then permutation P, presented on a valid/ready output handshake.

// des_sbox: one DES S-box; the 6-bit input is split into row {b1,b6} and column b2..b5 internally.
module des_sbox #(
    parameter logic [0:255] TBL = 256'h0
) (
    input  logic [5:0] i_data,
    output logic [3:0] o_data
);
    logic [5:0] w_idx;
    assign w_idx  = {i_data[5], i_data[0], i_data[4:1]};
    assign o_data = TBL[{w_idx, 2'b00} +: 4];
endmodule

module des_f_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r_in,
    input  logic [47:0] k_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_out,
    output logic [31:0] sbox_out,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Each table is row-major: 4 rows of 16 nibbles, first nibble = row 0 column 0.
    localparam logic [0:255] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [47:0] r_mix;
    logic [31:0] r_nib;
    logic [31:0] r_f;
    logic [31:0] r_sbox;
    logic [47:0] w_exp;
    logic [3:0]  w_sout [8];
    logic [3:0]  w_sel;
    logic [31:0] w_full;
    logic [31:0] w_p;

    // Expansion E: DES bit n of R is r_in[32-n].
    assign w_exp = {r_in[0], r_in[31:27], r_in[28:23], r_in[24:19], r_in[20:15],
                    r_in[16:11], r_in[12:7], r_in[8:3], r_in[4:0], r_in[31]};

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_sbox
            des_sbox #(.TBL(SBOX[g])) u_sbox (
                .i_data(r_mix[47-6*g -: 6]),
                .o_data(w_sout[g])
            );
        end
    endgenerate

    assign w_sel  = w_sout[r_cnt];
    assign w_full = {r_nib[31:4], w_sel};

    assign w_p = {w_full[16], w_full[25], w_full[12], w_full[11], w_full[3],  w_full[20], w_full[4],  w_full[15],
                  w_full[31], w_full[17], w_full[9],  w_full[6],  w_full[27], w_full[14], w_full[1],  w_full[22],
                  w_full[30], w_full[24], w_full[8],  w_full[18], w_full[0],  w_full[5],  w_full[29], w_full[23],
                  w_full[13], w_full[19], w_full[2],  w_full[26], w_full[10], w_full[21], w_full[28], w_full[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_mix   <= 48'd0;
            r_nib   <= 32'd0;
            r_f     <= 32'd0;
            r_sbox  <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_mix   <= w_exp ^ k_in;
                r_cnt   <= 3'd0;
                r_nib   <= 32'd0;
                r_state <= S_RUN;
            end
        end else if (r_state == S_RUN) begin
            r_nib[{~r_cnt, 2'b11} -: 4] <= w_sel;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_f     <= w_p;
                r_sbox  <= w_full;
                r_state <= S_DONE;
            end
        end else if (out_ready) begin
            r_state <= S_IDLE;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = !in_ready;
    assign f_out     = r_f;
    assign sbox_out  = r_sbox;
endmodule
